snake_body_map: RTL and testbench

- Sits directly downstream of the snake head-position generator and the body FIFO.
- Consumes head-push and tail-pop events and maintains a 16x8 occupancy bitmap that feeds the pixel generator / display path.
- Detects wall, self and board-full conditions, flags food eaten, and runs the game-state FSM (IDLE/RUN/OVER) that gates movement.

---
 rtl/snake_body_map.sv | 118 +++++++++++
 tb/tb_snake_body_map.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_map.sv
// Snake board occupancy map with collision detection and IDLE/RUN/OVER game FSM.
// Optional macro SNAKE_WRAP_EN: rows wrap vertically (y mod ROWS) instead of a wall hit.
module snake_body_map #(
  parameter int COLS  = 16,
  parameter int ROWS  = 8,
  parameter int LEN_W = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           head_pos,
  input  logic                 head_vld,
  input  logic [7:0]           tail_pos,
  input  logic                 tail_vld,
  input  logic [7:0]           food_pos,
  output logic [COLS*ROWS-1:0] occ_map,
  output logic [LEN_W-1:0]     length,
  output logic                 eat,
  output logic                 running,
  output logic                 game_over,
  output logic [1:0]           hit_code
);

  localparam int IDX_W = $clog2(COLS*ROWS);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'((1 << LEN_W) - 1);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t state;
  logic   start_q;
  logic   start_rise;

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             wall_hit;
  logic             tail_in;
  logic             food_hit;
  logic             same_cell;
  logic             self_hit;
  logic             full_hit;
  logic             tail_clr;
  logic             head_add;

  assign start_rise = start & ~start_q;

  // Cell index is {row, col}; only the low row bits address the board.
  assign head_idx = {head_pos[2:0], head_pos[7:4]};
  assign tail_idx = {tail_pos[2:0], tail_pos[7:4]};

`ifdef SNAKE_WRAP_EN
  assign wall_hit = 1'b0;
  assign tail_in  = tail_vld;
  assign food_hit = {head_pos[7:4], head_pos[2:0]} == {food_pos[7:4], food_pos[2:0]};
`else
  assign wall_hit = head_pos[3];
  assign tail_in  = tail_vld & ~tail_pos[3];
  assign food_hit = head_pos == food_pos;
`endif

  // Moving onto the cell the tail vacates this same cycle is a legal tail chase.
  assign same_cell = tail_in && (tail_idx == head_idx);
  assign self_hit  = occ_map[head_idx] && !same_cell;
  assign full_hit  = (length == MAX_LEN) && !tail_vld;

  // Popping an empty cell is a no-op, which also covers tail pops at length 0.
  assign tail_clr  = tail_in && occ_map[tail_idx];
  assign head_add  = head_vld && (!occ_map[head_idx] || same_cell);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      occ_map   <= '0;
      length    <= '0;
      eat       <= 1'b0;
      running   <= 1'b0;
      game_over <= 1'b0;
      hit_code  <= 2'd0;
    end else begin
      start_q <= start;
      eat     <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rise) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (head_vld && (wall_hit || self_hit || full_hit)) begin
            state     <= OVER;
            running   <= 1'b0;
            game_over <= 1'b1;
            hit_code  <= wall_hit ? 2'd1 : (self_hit ? 2'd2 : 2'd3);
          end else begin
            // Head set is written after tail clear so a shared cell ends set.
            if (tail_clr) occ_map[tail_idx] <= 1'b0;
            if (head_vld) occ_map[head_idx] <= 1'b1;
            if (head_add && !tail_clr)      length <= length + 1'b1;
            else if (!head_add && tail_clr) length <= length - 1'b1;
            eat <= head_vld && food_hit;
          end
        end
        OVER: begin
          if (start_rise) begin
            state     <= IDLE;
            game_over <= 1'b0;
            occ_map   <= '0;
            length    <= '0;
            hit_code  <= 2'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_map.sv
// Scoreboard bench for snake_body_map: expected records are queued as stimulus is
// driven and compared against the outputs observed one cycle later.
module tb_snake_body_map;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   head_pos = 8'h00;
  logic         head_vld = 1'b0;
  logic [7:0]   tail_pos = 8'h00;
  logic         tail_vld = 1'b0;
  logic [7:0]   food_pos = 8'hF7;
  logic [127:0] occ_map;
  logic [6:0]   length;
  logic         eat;
  logic         running;
  logic         game_over;
  logic [1:0]   hit_code;

  typedef struct packed {
    logic [127:0] occ;
    logic [6:0]   len;
    logic         eat;
    logic         run;
    logic         over;
    logic [1:0]   hit;
  } obs_t;

  obs_t sb[$];
  obs_t got_q[$];
  obs_t m;
  int   total = 0;
  int   passed = 0;

  snake_body_map dut (
    .clk(clk), .reset(reset), .start(start),
    .head_pos(head_pos), .head_vld(head_vld),
    .tail_pos(tail_pos), .tail_vld(tail_vld),
    .food_pos(food_pos), .occ_map(occ_map), .length(length),
    .eat(eat), .running(running), .game_over(game_over), .hit_code(hit_code)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.occ = occ_map; o.len = length; o.eat = eat;
    o.run = running; o.over = game_over; o.hit = hit_code;
    return o;
  endfunction

  function automatic int idx(input int x, input int y);
    return y * 16 + x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the resulting outputs are queued for comparison.
  task automatic drive(input logic hv, input logic [7:0] hp, input logic tv, input logic [7:0] tp);
    head_vld = hv; head_pos = hp; tail_vld = tv; tail_pos = tp;
    tick();
    head_vld = 1'b0; tail_vld = 1'b0;
    got_q.push_back(observe());
  endtask

  task automatic restart();
    reset = 1'b0; start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    start = 1'b1;
    tick();
    m = '0; m.run = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, g;
    reset = 1'b0;
    tick();
    sb.push_back('0); got_q.push_back(observe());
    restart();
    m.occ[idx(3,2)] = 1'b1; m.len = 1; sb.push_back(m);
    drive(1'b1, 8'h32, 1'b0, 8'h00);
    reset = 1'b0;
    #2;
    sb.push_back('0); got_q.push_back(observe());
    reset = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL test_reset: got occ=%h len=%0d eat=%b run=%b over=%b hit=%0d, want occ=%h len=%0d eat=%b run=%b over=%b hit=%0d",
                            g.occ, g.len, g.eat, g.run, g.over, g.hit, e.occ, e.len, e.eat, e.run, e.over, e.hit);
      else passed++;
    end
  endtask

  task automatic test_tail_same_cycle();
    obs_t e, g;
    restart();
    m.occ[0] = 1'b1; m.len = 1; sb.push_back(m); drive(1'b1, 8'h00, 1'b0, 8'h00);
    m.occ[1] = 1'b1; m.len = 2; sb.push_back(m); drive(1'b1, 8'h10, 1'b0, 8'h00);
    m.occ[2] = 1'b1; m.len = 3; sb.push_back(m); drive(1'b1, 8'h20, 1'b0, 8'h00);
    m.occ[3] = 1'b1; m.occ[0] = 1'b0; sb.push_back(m); drive(1'b1, 8'h30, 1'b1, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL test_tail_same_cycle: got occ=%h len=%0d eat=%b run=%b over=%b hit=%0d, want occ=%h len=%0d eat=%b run=%b over=%b hit=%0d",
                            g.occ, g.len, g.eat, g.run, g.over, g.hit, e.occ, e.len, e.eat, e.run, e.over, e.hit);
      else passed++;
    end
  endtask

  task automatic build_body();
    m.occ[idx(1,0)] = 1'b1; m.len = 1; sb.push_back(m); drive(1'b1, 8'h10, 1'b0, 8'h00);
    m.occ[idx(2,0)] = 1'b1; m.len = 2; sb.push_back(m); drive(1'b1, 8'h20, 1'b0, 8'h00);
    m.occ[idx(2,1)] = 1'b1; m.len = 3; sb.push_back(m); drive(1'b1, 8'h21, 1'b0, 8'h00);
    m.occ[idx(1,1)] = 1'b1; m.len = 4; sb.push_back(m); drive(1'b1, 8'h11, 1'b0, 8'h00);
  endtask

  task automatic test_self_hit();
    obs_t e, g;
    restart();
    build_body();
    m.run = 1'b0; m.over = 1'b1; m.hit = 2'd2; sb.push_back(m);
    drive(1'b1, 8'h10, 1'b1, 8'h20);
    sb.push_back(m); drive(1'b1, 8'h50, 1'b1, 8'h11);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL test_self_hit: got occ=%h len=%0d eat=%b run=%b over=%b hit=%0d, want occ=%h len=%0d eat=%b run=%b over=%b hit=%0d",
                            g.occ, g.len, g.eat, g.run, g.over, g.hit, e.occ, e.len, e.eat, e.run, e.over, e.hit);
      else passed++;
    end
  endtask

  task automatic test_tail_chase();
    obs_t e, g;
    restart();
    build_body();
    sb.push_back(m); drive(1'b1, 8'h20, 1'b1, 8'h20);
    m.occ[idx(1,1)] = 1'b0; m.len = 3; sb.push_back(m); drive(1'b0, 8'h00, 1'b1, 8'h11);
    sb.push_back(m); drive(1'b0, 8'h00, 1'b1, 8'h11);
    restart();
    sb.push_back(m); drive(1'b0, 8'h00, 1'b1, 8'h30);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL test_tail_chase: got occ=%h len=%0d eat=%b run=%b over=%b hit=%0d, want occ=%h len=%0d eat=%b run=%b over=%b hit=%0d",
                            g.occ, g.len, g.eat, g.run, g.over, g.hit, e.occ, e.len, e.eat, e.run, e.over, e.hit);
      else passed++;
    end
  endtask

  task automatic test_eat_wall();
    obs_t e, g;
    restart();
    food_pos = 8'h55;
    m.occ[idx(5,5)] = 1'b1; m.len = 1; m.eat = 1'b1; sb.push_back(m);
    drive(1'b1, 8'h55, 1'b0, 8'h00);
    m.eat = 1'b0; sb.push_back(m); drive(1'b0, 8'h00, 1'b0, 8'h00);
`ifdef SNAKE_WRAP_EN
    m.occ[idx(5,0)] = 1'b1; m.len = 2;
`else
    m.run = 1'b0; m.over = 1'b1; m.hit = 2'd1;
`endif
    sb.push_back(m); drive(1'b1, 8'h58, 1'b0, 8'h00);
    food_pos = 8'hF7;
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL test_eat_wall: got occ=%h len=%0d eat=%b run=%b over=%b hit=%0d, want occ=%h len=%0d eat=%b run=%b over=%b hit=%0d",
                            g.occ, g.len, g.eat, g.run, g.over, g.hit, e.occ, e.len, e.eat, e.run, e.over, e.hit);
      else passed++;
    end
  endtask

  // Fill 127 cells, then a head on the last free cell must end the game as full.
  task automatic test_full_and_restart();
    obs_t e, g;
    logic [6:0] i7;
    restart();
    for (int i = 0; i < 127; i++) begin
      i7 = 7'(i);
      m.occ[i] = 1'b1; m.len = 7'(i + 1);
      if (i == 0 || i == 63 || i == 126) sb.push_back(m);
      drive(1'b1, {i7[3:0], 1'b0, i7[6:4]}, 1'b0, 8'h00);
      if (!(i == 0 || i == 63 || i == 126)) void'(got_q.pop_back());
    end
    m.run = 1'b0; m.over = 1'b1; m.hit = 2'd3; sb.push_back(m);
    drive(1'b1, 8'hF7, 1'b0, 8'h00);
    sb.push_back(m); drive(1'b0, 8'h00, 1'b0, 8'h00);
    sb.push_back(m); drive(1'b1, 8'h00, 1'b1, 8'h00);
    start = 1'b0; sb.push_back(m); drive(1'b0, 8'h00, 1'b0, 8'h00);
    start = 1'b1; m = '0; sb.push_back(m); drive(1'b0, 8'h00, 1'b0, 8'h00);
    sb.push_back(m); drive(1'b1, 8'h10, 1'b0, 8'h00);
    start = 1'b0; sb.push_back(m); drive(1'b0, 8'h00, 1'b0, 8'h00);
    start = 1'b1; m.run = 1'b1; sb.push_back(m); drive(1'b0, 8'h00, 1'b0, 8'h00);
    m.occ[idx(1,0)] = 1'b1; m.len = 1; sb.push_back(m); drive(1'b1, 8'h10, 1'b0, 8'h00);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) $display("FAIL test_full_and_restart: got occ=%h len=%0d eat=%b run=%b over=%b hit=%0d, want occ=%h len=%0d eat=%b run=%b over=%b hit=%0d",
                            g.occ, g.len, g.eat, g.run, g.over, g.hit, e.occ, e.len, e.eat, e.run, e.over, e.hit);
      else passed++;
    end
  endtask

  initial begin
    m = '0;
    test_reset();
    test_tail_same_cycle();
    test_self_hit();
    test_tail_chase();
    test_eat_wall();
    test_full_and_restart();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
